cpu_sequencer: RTL and testbench

Multi-cycle control sequencer for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback using the opcode and write-enable produced by the instruction decoder. It shares the single memory port between instruction fetch and load/store traffic, and drives every datapath strobe: IR load, PC update, register-file write and memory request. It sits between the decoder and the PC, IR, register file and memory-port logic.

---
 rtl/cpu_pkg.sv | 51 +++++
 rtl/cpu_sequencer_wait_counter.sv | 31 +++
 rtl/cpu_sequencer.sv | 119 +++++++++++
 tb/tb_cpu_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32I multi-cycle sequencer: opcodes, state encoding,
// PC-source selects and small opcode classification helpers.
package cpu_pkg;

   localparam logic [6:0] OP_LOAD    = 7'h03;
   localparam logic [6:0] OP_STORE   = 7'h23;
   localparam logic [6:0] OP_ALU_REG = 7'h33;
   localparam logic [6:0] OP_ALU_IMM = 7'h13;
   localparam logic [6:0] OP_LUI     = 7'h37;
   localparam logic [6:0] OP_AUIPC   = 7'h17;
   localparam logic [6:0] OP_JAL     = 7'h6F;
   localparam logic [6:0] OP_JALR    = 7'h67;
   localparam logic [6:0] OP_BRANCH  = 7'h63;

   localparam logic [1:0] PC_PLUS4 = 2'd0;
   localparam logic [1:0] PC_IMM   = 2'd1;
   localparam logic [1:0] PC_ALU   = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_ERR    = 3'd6,
      S_TRAP   = 3'd7
   } seq_state_e;

   function automatic logic op_is_legal(input logic [6:0] op);
      case (op)
         OP_LOAD, OP_STORE, OP_ALU_REG, OP_ALU_IMM, OP_LUI,
         OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH: op_is_legal = 1'b1;
         default:                              op_is_legal = 1'b0;
      endcase
   endfunction

   function automatic logic op_is_mem(input logic [6:0] op);
      op_is_mem = (op == OP_LOAD) || (op == OP_STORE);
   endfunction

   function automatic logic [1:0] wb_pc_sel(input logic [6:0] op, input logic taken);
      case (op)
         OP_JAL:    wb_pc_sel = PC_IMM;
         OP_JALR:   wb_pc_sel = PC_ALU;
         OP_BRANCH: wb_pc_sel = taken ? PC_IMM : PC_PLUS4;
         default:   wb_pc_sel = PC_PLUS4;
      endcase
   endfunction

endpackage

// File: rtl/cpu_sequencer_wait_counter.sv
// Memory wait counter: counts consecutive unacknowledged request cycles and flags
// the cycle in which one more miss would reach MEM_TIMEOUT.
module seq_wait_counter #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic term_o
);

   localparam logic [15:0] TERM_CNT = 16'(MEM_TIMEOUT - 1);

   logic [15:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)     cnt_d = '0;
      else if (en_i) cnt_d = cnt_q + 16'd1;
   end

   // Terminal in the cycle whose miss would be the MEM_TIMEOUT-th consecutive one.
   assign term_o = en_i && (cnt_q == TERM_CNT);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the RV32I core.
// Define SEQ_TRAP_EN to build the TRAP state for illegal opcodes (otherwise they retire as NOP).
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   input  logic [6:0]  opcode,
   input  logic        reg_we_in,
   input  logic        branch_taken,
   input  logic        mem_ack,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_addr_sel,
   output logic        ir_we,
   output logic        pc_we,
   output logic [1:0]  pc_sel,
   output logic        rf_we,
   output logic        busy,
   output logic        error,
   output logic        trap,
   output logic [31:0] instret
);

   seq_state_e  state_q, state_d;
   logic [31:0] instret_q, instret_d;
   logic        wait_en, wait_clr, timeout;

   assign wait_en  = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ack;
   assign wait_clr = !wait_en;

   seq_wait_counter #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (wait_clr),
      .en_i   (wait_en),
      .term_o (timeout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         instret_q <= instret_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (run) state_d = S_FETCH;
         S_FETCH: begin
            if (mem_ack)      state_d = S_DECODE;
            else if (timeout) state_d = S_ERR;
         end
`ifdef SEQ_TRAP_EN
         S_DECODE: state_d = op_is_legal(opcode) ? S_EXEC : S_TRAP;
`else
         S_DECODE: state_d = S_EXEC;
`endif
         S_EXEC:   state_d = op_is_mem(opcode) ? S_MEM : S_WB;
         S_MEM: begin
            if (mem_ack)      state_d = S_WB;
            else if (timeout) state_d = S_ERR;
         end
         S_WB:     state_d = run ? S_FETCH : S_IDLE;
         S_ERR:    state_d = S_ERR;
`ifdef SEQ_TRAP_EN
         S_TRAP:   if (!run) state_d = S_IDLE;
`endif
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = PC_PLUS4;
      rf_we        = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req = 1'b1;
            ir_we   = mem_ack;
         end
         S_MEM: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = (opcode == OP_STORE);
         end
         // Illegal opcodes only reach WB in the NOP build, where they must not write rd.
         S_WB: begin
            pc_we  = 1'b1;
            rf_we  = reg_we_in && op_is_legal(opcode);
            pc_sel = op_is_legal(opcode) ? wb_pc_sel(opcode, branch_taken) : PC_PLUS4;
         end
         default: ;
      endcase
   end

   assign instret_d = (state_q == S_WB) ? instret_q + 32'd1 : instret_q;
   assign instret   = instret_q;
   assign error     = (state_q == S_ERR);
   assign busy      = (state_q != S_IDLE) && (state_q != S_ERR) && (state_q != S_TRAP);

`ifdef SEQ_TRAP_EN
   assign trap = (state_q == S_TRAP);
`else
   assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: per-instruction expectations are queued at issue
// and checked when the sequencer reaches writeback.
module tb_cpu_sequencer;

   typedef struct {
      logic        rf_we;
      logic [1:0]  pc_sel;
      logic        mem_we;
      int          lat;
      logic [31:0] instret;
   } sb_item_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run;
   logic [6:0]  opcode;
   logic        reg_we_in;
   logic        branch_taken;
   logic        mem_ack;
   logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, busy, error, trap;
   logic [1:0]  pc_sel;
   logic [31:0] instret;

   int          n_tests = 0;
   int          n_fail  = 0;
   sb_item_t    sb[$];
   logic [31:0] model_instret = '0;
   int          fetch_wait = 0;
   int          data_wait  = 0;
   bit          no_ack     = 1'b0;
   int          guard;

   cpu_sequencer #(.MEM_TIMEOUT(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .run          (run),
      .opcode       (opcode),
      .reg_we_in    (reg_we_in),
      .branch_taken (branch_taken),
      .mem_ack      (mem_ack),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr_sel (mem_addr_sel),
      .ir_we        (ir_we),
      .pc_we        (pc_we),
      .pc_sel       (pc_sel),
      .rf_we        (rf_we),
      .busy         (busy),
      .error        (error),
      .trap         (trap),
      .instret      (instret)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   function automatic logic exp_legal(input logic [6:0] op);
      return op inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63};
   endfunction

   function automatic logic [1:0] exp_pc_sel(input logic [6:0] op, input logic tk);
      if (op == 7'h6F) return 2'd1;
      if (op == 7'h67) return 2'd2;
      if (op == 7'h63) return tk ? 2'd1 : 2'd0;
      return 2'd0;
   endfunction

   // Memory responder and writeback monitor, both working on the falling edge.
   initial begin : mon
      int wcnt;
      int instr_cyc;
      sb_item_t it;
      wcnt = 0;
      instr_cyc = 0;
      mem_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (mem_req) begin
            mem_ack = no_ack ? 1'b0 : (wcnt >= (mem_addr_sel ? data_wait : fetch_wait));
            wcnt++;
         end else begin
            mem_ack = 1'b1;   // spurious ack outside a request must be ignored
            wcnt = 0;
         end
         #1;
         if (rst_n) begin
            if (busy) instr_cyc++;
            else begin
               instr_cyc = 0;
               check_eq("idle_strobes", {27'd0, mem_req, ir_we, pc_we, rf_we, mem_we}, 32'd0);
            end
            if (mem_req && !mem_addr_sel) begin
               check_eq("fetch_ir_we", ir_we, mem_ack);
               check_eq("fetch_mem_we", mem_we, 1'b0);
            end
            if (mem_req && mem_addr_sel && sb.size() != 0)
               check_eq("mem_we", mem_we, sb[0].mem_we);
            if (pc_we) begin
               if (sb.size() == 0) check_eq("wb_unexpected", sb.size(), 1);
               else begin
                  it = sb.pop_front();
                  check_eq("wb_rf_we", rf_we, it.rf_we);
                  check_eq("wb_pc_sel", pc_sel, it.pc_sel);
                  check_eq("wb_instret", instret, it.instret);
                  check_eq("wb_latency", instr_cyc, it.lat);
               end
               instr_cyc = 0;
            end
         end
      end
   end

   task automatic wait_sb_empty(input int budget);
      for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge clk);
      if (sb.size() != 0) begin
         check_eq("sb_drain_timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   task automatic exec_instr(input logic [6:0] op, input logic we, input logic tk,
                             input int fw, input int dw, input bit drop_in_mem);
      sb_item_t it;
      bit memop;
      memop      = (op == 7'h03) || (op == 7'h23);
      it.rf_we   = exp_legal(op) & we;
      it.pc_sel  = exp_legal(op) ? exp_pc_sel(op, tk) : 2'd0;
      it.mem_we  = (op == 7'h23);
      it.lat     = 4 + fw + (memop ? 1 + dw : 0);
      it.instret = model_instret;
      model_instret++;
      sb.push_back(it);
      @(posedge clk); #2;
      opcode = op; reg_we_in = we; branch_taken = tk;
      fetch_wait = fw; data_wait = dw;
      run = 1'b1;
      if (drop_in_mem) begin
         for (int i = 0; i < 40 && !(mem_req && mem_addr_sel); i++) @(negedge clk);
         check_eq("reach_mem", mem_req && mem_addr_sel, 1'b1);
      end else begin
         @(posedge clk); #2;
      end
      run = 1'b0;
      wait_sb_empty(60);
      @(posedge clk); #2;
      check_eq("back_to_idle", busy, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; run = 1'b0; opcode = 7'h00; reg_we_in = 1'b0; branch_taken = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check_eq("reset_outputs", {20'd0, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel,
                                 rf_we, busy, error, trap}, 32'd0);
      check_eq("reset_instret", instret, 32'd0);
      rst_n = 1'b1;

      exec_instr(7'h33, 1'b1, 1'b0, 0, 0, 1'b0);   // ALU_REG, zero-wait
      exec_instr(7'h03, 1'b1, 1'b0, 3, 3, 1'b0);   // LOAD, 3 waits on fetch and data
      exec_instr(7'h63, 1'b0, 1'b1, 0, 0, 1'b0);   // BRANCH taken
      exec_instr(7'h63, 1'b0, 1'b0, 1, 0, 1'b0);   // BRANCH not taken
      exec_instr(7'h67, 1'b1, 1'b0, 0, 0, 1'b0);   // JALR
      exec_instr(7'h6F, 1'b1, 1'b0, 2, 0, 1'b0);   // JAL
      exec_instr(7'h23, 1'b0, 1'b0, 0, 2, 1'b1);   // STORE, run dropped during MEM
      for (int k = 0; k < 4; k++)
         exec_instr((k % 2) ? 7'h13 : 7'h37, 1'b1, 1'b0, $urandom_range(0, 3), 0, 1'b0);

`ifdef SEQ_TRAP_EN
      @(posedge clk); #2;
      opcode = 7'h7F; reg_we_in = 1'b1; fetch_wait = 0; run = 1'b1;
      guard = 0;
      while (!trap && guard < 20) begin
         @(posedge clk); #2;
         guard++;
      end
      check_eq("trap_set", trap, 1'b1);
      check_eq("trap_busy", busy, 1'b0);
      check_eq("trap_instret", instret, model_instret);
      run = 1'b0;
      @(posedge clk); #2;
      check_eq("trap_clear", trap, 1'b0);
      check_eq("trap_idle_busy", busy, 1'b0);
`else
      exec_instr(7'h7F, 1'b1, 1'b0, 0, 0, 1'b0);   // illegal opcode retires as NOP
      check_eq("trap_tied_low", trap, 1'b0);
`endif
      check_eq("instret_total", instret, model_instret);

      // Asynchronous reset in the middle of a fetch.
      opcode = 7'h33; fetch_wait = 3; run = 1'b1;
      @(posedge clk); #2;
      check_eq("fetch_req", mem_req, 1'b1);
      rst_n = 1'b0;
      #1;
      check_eq("async_reset_outputs", {20'd0, mem_req, mem_we, mem_addr_sel, ir_we, pc_we,
                                       pc_sel, rf_we, busy, error, trap}, 32'd0);
      check_eq("async_reset_instret", instret, 32'd0);
      model_instret = '0;
      run = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b1;

      // Fetch timeout with MEM_TIMEOUT=4.
      no_ack = 1'b1; run = 1'b1;
      @(posedge clk); #2;
      repeat (3) begin @(posedge clk); #2; end
      check_eq("pre_timeout_error", error, 1'b0);
      check_eq("pre_timeout_req", mem_req, 1'b1);
      @(posedge clk); #2;
      check_eq("timeout_error", error, 1'b1);
      check_eq("timeout_busy", busy, 1'b0);
      no_ack = 1'b0;
      repeat (3) begin @(posedge clk); #2; end
      check_eq("error_sticky", error, 1'b1);
      check_eq("err_strobes", {27'd0, mem_req, ir_we, pc_we, rf_we, mem_we}, 32'd0);
      run = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b1;
      check_eq("error_cleared", error, 1'b0);
      @(posedge clk); #2;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
